// File: rtl/muldiv_ctrl.sv
// Execute-stage sequencer for the shared multi-cycle multiplier and divider.
// Launches a unit, stalls E until ready, then commits HI/LO exactly once.
module muldiv_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_validE,
    input  logic [1:0]  op_typeE,
    input  logic [31:0] src_aE,
    input  logic [31:0] src_bE,
    input  logic        stallE,
    input  logic        flushE,
    output logic        mul_start_o,
    output logic        div_start_o,
    output logic        sign_o,
    output logic [31:0] opa_o,
    output logic [31:0] opb_o,
    output logic        unit_flush_o,
    input  logic        mul_ready_i,
    input  logic        div_ready_i,
    input  logic [63:0] mul_result_i,
    input  logic [63:0] div_result_i,
    output logic        alustallE,
    output logic        hilo_writeE,
    output logic [63:0] hilo_wdataE,
    output logic        busy_o,
    output logic        timeout_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL_BUSY,
        DIV_BUSY,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   opa_q, opa_d;
    logic [31:0]   opb_q, opb_d;
    logic          sign_q, sign_d;
    logic [63:0]   result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          stall;
    logic          uflush;
    logic          rdy;
    logic [63:0]   res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            sign_q    <= 1'b0;
            result_q  <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            sign_q    <= sign_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        sign_d    = sign_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        stall     = 1'b0;
        uflush    = 1'b0;
        rdy       = (state_q == MUL_BUSY) ? mul_ready_i : div_ready_i;
        res       = (state_q == MUL_BUSY) ? mul_result_i : div_result_i;
        unique case (state_q)
            IDLE: begin
                if (op_validE && !flushE) begin
                    stall  = 1'b1;
                    opa_d  = src_aE;
                    opb_d  = src_bE;
                    sign_d = ~op_typeE[0];
                    // Divide-by-zero never reaches the divider
                    if (op_typeE[1] && (src_bE == 32'd0)) begin
                        result_d = {src_aE, 32'hFFFF_FFFF};
                        state_d  = DONE;
                    end else if (op_typeE[1]) begin
                        state_d = DIV_BUSY;
                    end else begin
                        state_d = MUL_BUSY;
                    end
                end
            end
            MUL_BUSY, DIV_BUSY: begin
                stall = 1'b1;
                if (flushE) begin
                    uflush  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (rdy) begin
                    result_d = res;
                    cnt_d    = '0;
                    state_d  = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    uflush    = 1'b1;
                    timeout_d = 1'b1;
                    result_d  = '0;
                    cnt_d     = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (!stallE || flushE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall is gated by reset so it drops while reset is held
    assign alustallE    = stall & rst;
    assign unit_flush_o = uflush;
    assign mul_start_o  = (state_q == MUL_BUSY);
    assign div_start_o  = (state_q == DIV_BUSY);
    assign sign_o       = sign_q;
    assign opa_o        = opa_q;
    assign opb_o        = opb_q;
    assign hilo_writeE  = (state_q == DONE) & ~stallE & ~flushE;
    assign hilo_wdataE  = result_q;
    assign busy_o       = (state_q != IDLE);
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: a TIMEOUT_CYCLES=64 instance for the
// main sequences and a TIMEOUT_CYCLES=8 instance for the watchdog.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_validE;
    logic [1:0]  op_typeE;
    logic [31:0] src_aE, src_bE;
    logic        stallE, flushE;
    logic        mul_ready_i, div_ready_i;
    logic [63:0] mul_result_i, div_result_i;

    logic        mul_start_o, div_start_o, sign_o, unit_flush_o;
    logic [31:0] opa_o, opb_o;
    logic        alustallE, hilo_writeE, busy_o, timeout_o;
    logic [63:0] hilo_wdataE;

    logic        w_mul_start_o, w_div_start_o, w_sign_o, w_unit_flush_o;
    logic [31:0] w_opa_o, w_opb_o;
    logic        w_alustallE, w_hilo_writeE, w_busy_o, w_timeout_o;
    logic [63:0] w_hilo_wdataE;

    int checks = 0;
    int errors = 0;
    int stall_cnt, wr_cnt, uf_cnt, dstart_seen;
    logic [63:0] wdata_seen;

    always #5 clk = ~clk;

    muldiv_ctrl #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .op_validE(op_validE), .op_typeE(op_typeE),
        .src_aE(src_aE), .src_bE(src_bE),
        .stallE(stallE), .flushE(flushE),
        .mul_start_o(mul_start_o), .div_start_o(div_start_o),
        .sign_o(sign_o), .opa_o(opa_o), .opb_o(opb_o),
        .unit_flush_o(unit_flush_o),
        .mul_ready_i(mul_ready_i), .div_ready_i(div_ready_i),
        .mul_result_i(mul_result_i), .div_result_i(div_result_i),
        .alustallE(alustallE), .hilo_writeE(hilo_writeE),
        .hilo_wdataE(hilo_wdataE), .busy_o(busy_o),
        .timeout_o(timeout_o)
    );

    muldiv_ctrl #(.TIMEOUT_CYCLES(8)) dut_wd (
        .clk(clk), .rst(rst),
        .op_validE(op_validE), .op_typeE(op_typeE),
        .src_aE(src_aE), .src_bE(src_bE),
        .stallE(stallE), .flushE(flushE),
        .mul_start_o(w_mul_start_o), .div_start_o(w_div_start_o),
        .sign_o(w_sign_o), .opa_o(w_opa_o), .opb_o(w_opb_o),
        .unit_flush_o(w_unit_flush_o),
        .mul_ready_i(mul_ready_i), .div_ready_i(div_ready_i),
        .mul_result_i(mul_result_i), .div_result_i(div_result_i),
        .alustallE(w_alustallE), .hilo_writeE(w_hilo_writeE),
        .hilo_wdataE(w_hilo_wdataE), .busy_o(w_busy_o),
        .timeout_o(w_timeout_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        if (alustallE) stall_cnt++;
        if (unit_flush_o) uf_cnt++;
        if (div_start_o) dstart_seen++;
        if (hilo_writeE) begin
            wr_cnt++;
            wdata_seen = hilo_wdataE;
        end
    endtask

    task automatic clr();
        stall_cnt = 0; wr_cnt = 0; uf_cnt = 0;
        dstart_seen = 0; wdata_seen = '0;
    endtask

    initial begin
        rst = 1'b0; op_validE = 0; op_typeE = 0;
        src_aE = 0; src_bE = 0; stallE = 0; flushE = 0;
        mul_ready_i = 0; div_ready_i = 0;
        mul_result_i = 0; div_result_i = 0;

        // Reset state
        @(negedge clk);
        chk("rst_alustall", alustallE, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_write", hilo_writeE, 0);
        chk("rst_wdata", hilo_wdataE, 0);
        chk("rst_opa", opa_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_starts", {mul_start_o, div_start_o, unit_flush_o}, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // MULT -2 * 3, ready in the 4th busy cycle
        clr();
        for (int i = 0; i <= 5; i++) begin
            op_validE = 1; op_typeE = 2'b00;
            src_aE = 32'hFFFF_FFFE; src_bE = 32'd3;
            mul_ready_i = (i == 4);
            mul_result_i = 64'hFFFF_FFFF_FFFF_FFFA;
            @(negedge clk);
            sample();
            if (i == 0) chk("mult_start_a", mul_start_o, 0);
            if (i == 1) begin
                chk("mult_start", mul_start_o, 1);
                chk("mult_sign", sign_o, 1);
                chk("mult_opa", opa_o, 32'hFFFF_FFFE);
                chk("mult_opb", opb_o, 32'd3);
            end
            if (i == 5) begin
                chk("mult_write", hilo_writeE, 1);
                chk("mult_wdata", hilo_wdataE, 64'hFFFF_FFFF_FFFF_FFFA);
            end
            @(posedge clk); #1;
        end
        mul_ready_i = 0;
        chk("mult_stall_cycles", stall_cnt, 5);
        chk("mult_write_count", wr_cnt, 1);

        // DIV 5 / 0 accepted back-to-back, bypasses the divider
        clr();
        for (int i = 0; i <= 2; i++) begin
            op_validE = (i <= 1); op_typeE = 2'b10;
            src_aE = 32'd5; src_bE = 32'd0;
            @(negedge clk);
            sample();
            if (i == 0) chk("dz_accept_stall", alustallE, 1);
            if (i == 1) begin
                chk("dz_write", hilo_writeE, 1);
                chk("dz_wdata", hilo_wdataE, 64'h0000_0005_FFFF_FFFF);
                chk("dz_no_stall", alustallE, 0);
            end
            @(posedge clk); #1;
        end
        chk("dz_no_div_start", dstart_seen, 0);
        chk("dz_stall_cycles", stall_cnt, 1);
        chk("dz_write_count", wr_cnt, 1);

        // MULTU that never completes: watchdog on the 8-cycle instance
        for (int i = 0; i <= 10; i++) begin
            op_validE = (i <= 9); op_typeE = 2'b01;
            src_aE = 32'd7; src_bE = 32'd9;
            @(negedge clk);
            if (i == 0) chk("wd_accept", w_alustallE, 1);
            if (i == 1) begin
                chk("wd_sign", w_sign_o, 0);
                chk("wd_start", w_mul_start_o, 1);
            end
            if (i == 7) chk("wd_flush_early", w_unit_flush_o, 0);
            if (i == 8) begin
                chk("wd_flush", w_unit_flush_o, 1);
                chk("wd_timeout_pre", w_timeout_o, 0);
            end
            if (i == 9) begin
                chk("wd_timeout", w_timeout_o, 1);
                chk("wd_write", w_hilo_writeE, 1);
                chk("wd_wdata", w_hilo_wdataE, 64'h0);
                chk("wd_main_no_timeout", timeout_o, 0);
            end
            if (i == 10) begin
                chk("wd_idle", w_busy_o, 0);
                chk("wd_sticky", w_timeout_o, 1);
            end
            @(posedge clk); #1;
        end

        rst = 1'b0;
        @(negedge clk);
        chk("rst2_busy", busy_o, 0);
        chk("rst2_timeout", w_timeout_o, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // DIVU 100 / 7, ready after 33 cycles, commit deferred by stallE
        clr();
        for (int i = 0; i <= 37; i++) begin
            op_validE = (i <= 36); op_typeE = 2'b11;
            src_aE = 32'd100; src_bE = 32'd7;
            div_ready_i = (i == 33);
            div_result_i = 64'h0000_0002_0000_000E;
            mul_ready_i = (i == 10);
            mul_result_i = 64'hDEAD_BEEF_DEAD_BEEF;
            stallE = (i == 34 || i == 35);
            @(negedge clk);
            sample();
            if (i == 11) chk("divu_ignore_mul_ready", div_start_o, 1);
            if (i == 34) begin
                chk("divu_deferred", hilo_writeE, 0);
                chk("divu_wdata_held", hilo_wdataE, 64'h0000_0002_0000_000E);
            end
            if (i == 36) chk("divu_write", hilo_writeE, 1);
            @(posedge clk); #1;
        end
        mul_ready_i = 0; div_ready_i = 0; stallE = 0;
        chk("divu_stall_cycles", stall_cnt, 34);
        chk("divu_write_count", wr_cnt, 1);
        chk("divu_wdata", wdata_seen, 64'h0000_0002_0000_000E);

        // DIV flushed in the same cycle as ready
        clr();
        for (int i = 0; i <= 12; i++) begin
            op_validE = (i <= 10); op_typeE = 2'b10;
            src_aE = 32'd20; src_bE = 32'd3;
            div_ready_i = (i == 10);
            div_result_i = 64'h0000_0002_0000_0006;
            flushE = (i == 10);
            @(negedge clk);
            sample();
            if (i == 10) chk("fl_unit_flush", unit_flush_o, 1);
            if (i == 11) chk("fl_idle", busy_o, 0);
            @(posedge clk); #1;
        end
        div_ready_i = 0; flushE = 0;
        chk("fl_no_write", wr_cnt, 0);
        chk("fl_flush_pulses", uf_cnt, 1);
        chk("fl_no_capture", hilo_wdataE, 64'h0000_0002_0000_000E);

        // Reset in the middle of DIV_BUSY, then clean re-accept
        for (int i = 0; i <= 3; i++) begin
            op_validE = 1; op_typeE = 2'b10;
            src_aE = 32'd40; src_bE = 32'd5;
            @(negedge clk);
            if (i == 3) chk("mr_busy_div", div_start_o, 1);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        chk("mr_div_start", div_start_o, 0);
        chk("mr_alustall", alustallE, 0);
        chk("mr_busy", busy_o, 0);
        chk("mr_opa", opa_o, 0);
        chk("mr_sign", sign_o, 0);
        chk("mr_wdata", hilo_wdataE, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        clr();
        for (int i = 0; i <= 5; i++) begin
            op_validE = (i <= 4);
            div_ready_i = (i == 3);
            div_result_i = 64'h0000_0000_0000_0008;
            @(negedge clk);
            sample();
            if (i == 0) chk("mr_reaccept", alustallE, 1);
            if (i == 1) begin
                chk("mr_restart", div_start_o, 1);
                chk("mr_opa2", opa_o, 32'd40);
            end
            if (i == 4) chk("mr_write", hilo_writeE, 1);
            @(posedge clk); #1;
        end
        chk("mr_write_count", wr_cnt, 1);
        chk("mr_wdata2", wdata_seen, 64'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
